// File: rtl/lsq_port_arbiter_pkg.sv
// lsq_port_arbiter_pkg: shared field positions, widths and request record
package lsq_port_arbiter_pkg;
   localparam int LSQ_VALID_BIT = 15;
   localparam int LSQ_SRC_BIT   = 14;
   localparam int ADDR_W        = 32;
   localparam int DATA_W        = 32;
   localparam int CNTRL_W       = 14;
   localparam int Z_W           = 4;
   localparam int CNT_W         = 4;

   typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

   typedef struct packed {
      logic               rw;
      logic [ADDR_W-1:0]  addr;
      logic [DATA_W-1:0]  data;
      logic [CNTRL_W-1:0] cntrl;
      logic [Z_W-1:0]     z;
   } req_t;
endpackage

// File: rtl/lsq_port_arbiter_if.sv
// lsq_port_arbiter_if: requester, LSQ issue/response and status bundle
interface lsq_port_arbiter_if;
   import lsq_port_arbiter_pkg::*;
   logic               a_valid, a_ready, a_rw, b_valid, b_ready, b_rw;
   logic [ADDR_W-1:0]  a_addr, b_addr, lsq_addr;
   logic [DATA_W-1:0]  a_data, b_data, lsq_data, lsq_data_out;
   logic [CNTRL_W-1:0] a_cntrl, b_cntrl, a_rsp_cntrl, b_rsp_cntrl;
   logic [Z_W-1:0]     a_Z, b_Z, lsq_Z, lsq_Z_out, a_rsp_Z, b_rsp_Z;
   logic               lsq_rw, lsq_stall;
   logic [15:0]        lsq_cntrl, lsq_cntrl_out;
   logic               a_rsp_valid, b_rsp_valid;
   logic [DATA_W-1:0]  a_rsp_data, b_rsp_data;
   logic               err, idle;

   modport slave (
      input  a_valid, a_rw, a_addr, a_data, a_cntrl, a_Z,
      input  b_valid, b_rw, b_addr, b_data, b_cntrl, b_Z,
      input  lsq_stall, lsq_data_out, lsq_cntrl_out, lsq_Z_out,
      output a_ready, b_ready, lsq_rw, lsq_addr, lsq_data, lsq_cntrl, lsq_Z,
      output a_rsp_valid, a_rsp_data, a_rsp_cntrl, a_rsp_Z,
      output b_rsp_valid, b_rsp_data, b_rsp_cntrl, b_rsp_Z, err, idle
   );

   modport master (
      output a_valid, a_rw, a_addr, a_data, a_cntrl, a_Z,
      output b_valid, b_rw, b_addr, b_data, b_cntrl, b_Z,
      output lsq_stall, lsq_data_out, lsq_cntrl_out, lsq_Z_out,
      input  a_ready, b_ready, lsq_rw, lsq_addr, lsq_data, lsq_cntrl, lsq_Z,
      input  a_rsp_valid, a_rsp_data, a_rsp_cntrl, a_rsp_Z,
      input  b_rsp_valid, b_rsp_data, b_rsp_cntrl, b_rsp_Z, err, idle
   );
endinterface

// File: rtl/lsq_credit_counter.sv
// lsq_credit_counter: in-flight request count for one requester
module lsq_credit_counter
   import lsq_port_arbiter_pkg::*;
#(
   parameter int MAX_OUT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_underflow
);
   logic [CNT_W-1:0] r_count;

   assign o_count     = r_count;
   assign o_full      = r_count >= CNT_W'(MAX_OUT);
   // a response with nothing in flight is dropped rather than wrapping the count
   assign o_underflow = i_dec & (r_count == '0);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_count <= '0;
      else        r_count <= r_count + CNT_W'(i_inc) - CNT_W'(i_dec & ~o_underflow);
endmodule

// File: rtl/lsq_port_arbiter.sv
// lsq_port_arbiter: round-robin two-requester front end with one registered
// LSQ issue slot, per-requester credits and tagged response routing
module lsq_port_arbiter
   import lsq_port_arbiter_pkg::*;
#(
   parameter int MAX_OUT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   lsq_port_arbiter_if.slave   bus
);
   logic [CNT_W-1:0] w_a_cnt, w_b_cnt;
   logic             w_a_full, w_b_full, w_a_uf, w_b_uf;
   logic             w_slot_free, w_a_elig, w_b_elig, w_gnt_a, w_gnt_b;
   logic             w_rsp_a, w_rsp_b, w_fwd_a, w_fwd_b;
   req_t             w_req_a, w_req_b, r_req;
   logic             r_slot_v, r_err;
   src_e             r_src, r_rr_last;
   logic             r_a_rsp_v, r_b_rsp_v;
   logic [DATA_W-1:0]  r_a_rsp_data, r_b_rsp_data;
   logic [CNTRL_W-1:0] r_a_rsp_cntrl, r_b_rsp_cntrl;
   logic [Z_W-1:0]     r_a_rsp_z, r_b_rsp_z;

   assign w_req_a     = {bus.a_rw, bus.a_addr, bus.a_data, bus.a_cntrl, bus.a_Z};
   assign w_req_b     = {bus.b_rw, bus.b_addr, bus.b_data, bus.b_cntrl, bus.b_Z};
   assign w_slot_free = ~r_slot_v | ~bus.lsq_stall;
   assign w_a_elig    = bus.a_valid & ~w_a_full;
   assign w_b_elig    = bus.b_valid & ~w_b_full;
   // on a tie the requester not granted last wins
   assign w_gnt_a     = w_slot_free & w_a_elig & (~w_b_elig | (r_rr_last == SRC_B));
   assign w_gnt_b     = w_slot_free & w_b_elig & ~w_gnt_a;
   assign w_rsp_a     = bus.lsq_cntrl_out[LSQ_VALID_BIT] & ~bus.lsq_cntrl_out[LSQ_SRC_BIT];
   assign w_rsp_b     = bus.lsq_cntrl_out[LSQ_VALID_BIT] &  bus.lsq_cntrl_out[LSQ_SRC_BIT];
   assign w_fwd_a     = w_rsp_a & ~w_a_uf;
   assign w_fwd_b     = w_rsp_b & ~w_b_uf;

   lsq_credit_counter #(.MAX_OUT(MAX_OUT)) u_cnt_a (
      .clk(clk), .rst_n(rst_n), .i_inc(w_gnt_a), .i_dec(w_rsp_a),
      .o_count(w_a_cnt), .o_full(w_a_full), .o_underflow(w_a_uf)
   );

   lsq_credit_counter #(.MAX_OUT(MAX_OUT)) u_cnt_b (
      .clk(clk), .rst_n(rst_n), .i_inc(w_gnt_b), .i_dec(w_rsp_b),
      .o_count(w_b_cnt), .o_full(w_b_full), .o_underflow(w_b_uf)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_slot_v  <= 1'b0;
         r_src     <= SRC_A;
         r_req     <= '0;
         r_rr_last <= SRC_B;
      end else if (w_gnt_a | w_gnt_b) begin
         r_slot_v  <= 1'b1;
         r_src     <= w_gnt_b ? SRC_B : SRC_A;
         r_req     <= w_gnt_b ? w_req_b : w_req_a;
         r_rr_last <= w_gnt_b ? SRC_B : SRC_A;
      end else if (w_slot_free) begin
         r_slot_v  <= 1'b0;
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_a_rsp_v     <= 1'b0;
         r_b_rsp_v     <= 1'b0;
         r_a_rsp_data  <= '0;
         r_b_rsp_data  <= '0;
         r_a_rsp_cntrl <= '0;
         r_b_rsp_cntrl <= '0;
         r_a_rsp_z     <= '0;
         r_b_rsp_z     <= '0;
         r_err         <= 1'b0;
      end else begin
         r_a_rsp_v <= w_fwd_a;
         r_b_rsp_v <= w_fwd_b;
         r_err     <= r_err | w_a_uf | w_b_uf;
         if (w_fwd_a) begin
            r_a_rsp_data  <= bus.lsq_data_out;
            r_a_rsp_cntrl <= bus.lsq_cntrl_out[CNTRL_W-1:0];
            r_a_rsp_z     <= bus.lsq_Z_out;
         end
         if (w_fwd_b) begin
            r_b_rsp_data  <= bus.lsq_data_out;
            r_b_rsp_cntrl <= bus.lsq_cntrl_out[CNTRL_W-1:0];
            r_b_rsp_z     <= bus.lsq_Z_out;
         end
      end

   assign bus.a_ready     = w_gnt_a;
   assign bus.b_ready     = w_gnt_b;
   assign bus.lsq_rw      = r_req.rw;
   assign bus.lsq_addr    = r_req.addr;
   assign bus.lsq_data    = r_req.data;
   assign bus.lsq_cntrl   = {r_slot_v, r_src, r_req.cntrl};
   assign bus.lsq_Z       = r_req.z;
   assign bus.a_rsp_valid = r_a_rsp_v;
   assign bus.a_rsp_data  = r_a_rsp_data;
   assign bus.a_rsp_cntrl = r_a_rsp_cntrl;
   assign bus.a_rsp_Z     = r_a_rsp_z;
   assign bus.b_rsp_valid = r_b_rsp_v;
   assign bus.b_rsp_data  = r_b_rsp_data;
   assign bus.b_rsp_cntrl = r_b_rsp_cntrl;
   assign bus.b_rsp_Z     = r_b_rsp_z;
   assign bus.err         = r_err;
   assign bus.idle        = ~r_slot_v & (w_a_cnt == '0) & (w_b_cnt == '0);
endmodule

// File: tb/tb_lsq_port_arbiter.sv
// tb_lsq_port_arbiter: directed table vectors plus hand-written stall,
// credit, error and reset sequences
module tb_lsq_port_arbiter;
   logic clk, rst_n;
   int   total = 0, bad = 0;

   lsq_port_arbiter_if bus ();

   lsq_port_arbiter #(.MAX_OUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic        av, bv, stall;
      logic [15:0] rc;
      logic [31:0] rd;
      logic        ea, eb;
      logic [15:0] elc;
      logic        ears, ebrs, eidle;
   } vec_t;

   vec_t tv [8];

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n             = 1'b1;
      bus.a_valid       = 0; bus.b_valid = 0; bus.lsq_stall = 0;
      bus.a_rw          = 0; bus.a_addr = 32'h100; bus.a_data = 32'hAAAA0000;
      bus.a_cntrl       = 14'h0011; bus.a_Z = 4'h1;
      bus.b_rw          = 1; bus.b_addr = 32'h200; bus.b_data = 32'hBBBB0000;
      bus.b_cntrl       = 14'h0022; bus.b_Z = 4'h2;
      bus.lsq_cntrl_out = 0; bus.lsq_data_out = 0; bus.lsq_Z_out = 4'h5;
      #5 rst_n = 1'b0;
      #1;
      chk("rst_lsq_cntrl", 32'(bus.lsq_cntrl), 0);
      chk("rst_lsq_addr", bus.lsq_addr, 0);
      chk("rst_a_ready", 32'(bus.a_ready), 0);
      chk("rst_rsp_valid", 32'({bus.a_rsp_valid, bus.b_rsp_valid}), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_idle", 32'(bus.idle), 1);
      #6 rst_n = 1'b1;
      step();

      // contention A,B,A,B then responses draining credits
      tv[0] = '{1, 1, 0, 16'h0000, 32'h0, 1, 0, 16'h8011, 0, 0, 0};
      tv[1] = '{1, 1, 0, 16'h0000, 32'h0, 0, 1, 16'hC022, 0, 0, 0};
      tv[2] = '{1, 1, 0, 16'h0000, 32'h0, 1, 0, 16'h8011, 0, 0, 0};
      tv[3] = '{1, 1, 0, 16'h0000, 32'h0, 0, 1, 16'hC022, 0, 0, 0};
      tv[4] = '{0, 0, 0, 16'h8000, 32'h11111111, 0, 0, 16'h4022, 1, 0, 0};
      tv[5] = '{0, 0, 0, 16'hC005, 32'h0BADF00D, 0, 0, 16'h4022, 0, 1, 0};
      tv[6] = '{0, 0, 0, 16'h8000, 32'h12345678, 0, 0, 16'h4022, 1, 0, 0};
      tv[7] = '{0, 0, 0, 16'hC00A, 32'hDEADBEEF, 0, 0, 16'h4022, 0, 1, 1};
      for (int i = 0; i < 8; i++) begin
         bus.a_valid = tv[i].av; bus.b_valid = tv[i].bv; bus.lsq_stall = tv[i].stall;
         bus.lsq_cntrl_out = tv[i].rc; bus.lsq_data_out = tv[i].rd;
         #1;
         chk($sformatf("v%0d_a_ready", i), 32'(bus.a_ready), 32'(tv[i].ea));
         chk($sformatf("v%0d_b_ready", i), 32'(bus.b_ready), 32'(tv[i].eb));
         step();
         chk($sformatf("v%0d_lsq_cntrl", i), 32'(bus.lsq_cntrl), 32'(tv[i].elc));
         chk($sformatf("v%0d_a_rsp_valid", i), 32'(bus.a_rsp_valid), 32'(tv[i].ears));
         chk($sformatf("v%0d_b_rsp_valid", i), 32'(bus.b_rsp_valid), 32'(tv[i].ebrs));
         chk($sformatf("v%0d_idle", i), 32'(bus.idle), 32'(tv[i].eidle));
      end
      bus.a_valid = 0; bus.b_valid = 0; bus.lsq_cntrl_out = 0; bus.lsq_data_out = 0;
      chk("route_b_cntrl", 32'(bus.b_rsp_cntrl), 32'h000A);
      chk("route_b_data", bus.b_rsp_data, 32'hDEADBEEF);
      chk("route_a_data", bus.a_rsp_data, 32'h12345678);

      // stall hold
      bus.a_valid = 1;
      #1 chk("stall_a_ready", 32'(bus.a_ready), 1);
      step();
      chk("stall_issue_addr", bus.lsq_addr, 32'h100);
      chk("stall_issue_cntrl", 32'(bus.lsq_cntrl), 32'h8011);
      bus.b_valid = 1; bus.lsq_stall = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("stall%0d_ready", i), 32'({bus.a_ready, bus.b_ready}), 0);
         step();
         chk($sformatf("stall%0d_addr", i), bus.lsq_addr, 32'h100);
         chk($sformatf("stall%0d_cntrl", i), 32'(bus.lsq_cntrl), 32'h8011);
      end
      bus.lsq_stall = 0;
      #1;
      chk("unstall_b_ready", 32'(bus.b_ready), 1);
      chk("unstall_a_ready", 32'(bus.a_ready), 0);
      step();
      chk("unstall_addr", bus.lsq_addr, 32'h200);
      chk("unstall_rw", 32'(bus.lsq_rw), 1);
      chk("unstall_data", bus.lsq_data, 32'hBBBB0000);
      bus.a_valid = 0; bus.b_valid = 0;
      bus.lsq_cntrl_out = 16'h8000; step();
      bus.lsq_cntrl_out = 16'hC000; step();
      bus.lsq_cntrl_out = 0; step();
      chk("stall_idle", 32'(bus.idle), 1);

      // credit limit on A
      bus.a_valid = 1;
      for (int i = 0; i < 4; i++) begin
         #1 chk($sformatf("cred%0d_a_ready", i), 32'(bus.a_ready), 1);
         step();
      end
      bus.b_valid = 1;
      #1;
      chk("cred_full_a_ready", 32'(bus.a_ready), 0);
      chk("cred_full_b_ready", 32'(bus.b_ready), 1);
      bus.b_valid = 0; bus.lsq_cntrl_out = 16'h8000;
      #1 chk("cred_rsp_a_ready", 32'(bus.a_ready), 0);
      step();
      bus.lsq_cntrl_out = 0;
      #1;
      chk("cred_free_a_ready", 32'(bus.a_ready), 1);
      chk("cred_a_rsp_valid", 32'(bus.a_rsp_valid), 1);

      // same-cycle issue and response: A count stays at 3
      bus.lsq_cntrl_out = 16'h8000;
      step();
      bus.lsq_cntrl_out = 0;
      #1;
      chk("same_a_ready", 32'(bus.a_ready), 1);
      chk("same_a_rsp_valid", 32'(bus.a_rsp_valid), 1);
      step();
      chk("same_full_a_ready", 32'(bus.a_ready), 0);
      bus.a_valid = 0;

      // drain, then underflow
      bus.lsq_cntrl_out = 16'h8000;
      for (int i = 0; i < 4; i++) step();
      bus.lsq_cntrl_out = 0;
      step();
      chk("drain_idle", 32'(bus.idle), 1);
      chk("drain_err", 32'(bus.err), 0);
      bus.lsq_cntrl_out = 16'h8000;
      step();
      bus.lsq_cntrl_out = 0;
      chk("uf_err", 32'(bus.err), 1);
      chk("uf_dropped", 32'(bus.a_rsp_valid), 0);
      step(); step();
      chk("uf_err_sticky", 32'(bus.err), 1);
      chk("uf_idle", 32'(bus.idle), 1);

      // reset mid-operation
      bus.a_valid = 1;
      step();
      bus.a_valid = 0;
      chk("busy_idle", 32'(bus.idle), 0);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_idle", 32'(bus.idle), 1);
      chk("midrst_err", 32'(bus.err), 0);
      chk("midrst_cntrl", 32'(bus.lsq_cntrl), 0);
      #2 rst_n = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
